// File: rtl/serial_byte_receiver_pkg.sv
// Shared types and constants for the serial byte receiver.
// States, line levels and the default word width.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic SER_IDLE_LVL  = 1'b1;
  localparam logic SER_START_LVL = 1'b0;
  localparam logic SER_STOP_LVL  = 1'b1;

  localparam int SER_DATA_W = 8;

endpackage

// File: rtl/serial_byte_receiver_shift.sv
// Right-shift register for the serial receiver.
// New bits enter at the MSB; the first bit received ends up at bit 0.
module rx_shift_reg
  import serial_pkg::*;
#(
  parameter int DATA_W = SER_DATA_W
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_q <= '0;
    end else if (i_shift) begin
      r_q <= {i_bit, r_q[DATA_W-1:1]};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_byte_receiver.sv
// Serial-in/parallel-out receiver, LSB first, start/stop framed.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit before stop.
module serial_byte_receiver
  import serial_pkg::*;
#(
  parameter int DATA_W = SER_DATA_W,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_en,
  input  logic              ser_in,
  input  logic              out_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

`ifdef SERIAL_RX_PARITY_EN
  localparam rx_state_t LAST_NXT = PARITY;
`else
  localparam rx_state_t LAST_NXT = STOP;
`endif

  rx_state_t         r_state;
  rx_state_t         w_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_q;
  logic              r_valid;
  logic              r_busy;
  logic              r_ferr;
  logic              r_ovr;
  logic              r_perr;
  logic              w_start;
  logic              w_shift;
  logic              w_good;
  logic              w_ferr;
  logic              w_perr;
  logic              w_last;
  logic              w_pbad;

  assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

  rx_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk     (clk),
    .i_clr   (reset | w_start),
    .i_shift (w_shift),
    .i_bit   (ser_in),
    .o_q     (w_q)
  );

`ifdef SERIAL_RX_PARITY_EN
  logic r_pbad;

  // Latched parity verdict, reported only once the stop bit is good
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pbad <= 1'b0;
    end else if (bit_en && r_state == PARITY) begin
      r_pbad <= (^w_q) ^ ser_in;
    end
  end

  assign w_pbad = r_pbad;
`else
  assign w_pbad = 1'b0;
`endif

  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    w_shift = 1'b0;
    w_good  = 1'b0;
    w_ferr  = 1'b0;
    w_perr  = 1'b0;
    if (bit_en) begin
      unique case (r_state)
        IDLE: begin
          if (ser_in == SER_START_LVL) begin
            w_nxt   = DATA;
            w_start = 1'b1;
          end
        end
        DATA: begin
          w_shift = 1'b1;
          if (w_last) w_nxt = LAST_NXT;
        end
        PARITY: w_nxt = STOP;
        STOP: begin
          w_nxt = IDLE;
          if (ser_in == SER_STOP_LVL) begin
            w_perr = w_pbad;
            w_good = ~w_pbad;
          end else begin
            w_ferr = 1'b1;
          end
        end
        default: w_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= (w_nxt != IDLE);
      r_ferr  <= w_ferr;
      r_perr  <= w_perr;
      r_ovr   <= 1'b0;
      if (w_start) begin
        r_cnt <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // A landing word wins over a same-edge ack
      if (w_good) begin
        if (!r_valid || out_ack) begin
          r_data  <= w_q;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && out_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_out   = r_data;
  assign out_valid  = r_valid;
  assign busy       = r_busy;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign parity_err = r_perr;

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Directed bench for serial_byte_receiver.
// Build with SERIAL_RX_PARITY_EN to exercise the parity frames.
module tb_serial_byte_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_en = 1'b0;
  logic       ser_in = 1'b1;
  logic       out_ack = 1'b0;
  logic [7:0] data_out;
  logic       out_valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  int checks = 0;
  int errors = 0;

  serial_byte_receiver #(
    .DATA_W (8),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_en     (bit_en),
    .ser_in     (ser_in),
    .out_ack    (out_ack),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap, input logic ack);
    repeat (gap) begin
      bit_en = 1'b0;
      ser_in = ~ser_in;
      tick();
    end
    bit_en  = 1'b1;
    ser_in  = b;
    out_ack = ack;
    tick();
    bit_en  = 1'b0;
    out_ack = 1'b0;
    ser_in  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stp,
                            input int gap, input logic ack_stop);
    strobe(1'b0, gap, 1'b0);
    for (int i = 0; i < 8; i++) strobe(d[i], gap, 1'b0);
`ifdef SERIAL_RX_PARITY_EN
    strobe(^d, gap, 1'b0);
`endif
    strobe(stp, gap, ack_stop);
  endtask

  task automatic ack_once();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  initial begin
    tick();
    chk("rst_data", 16'(data_out), 16'h00);
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_ferr", 16'(frame_err), 16'h0);
    chk("rst_ovr", 16'(overrun), 16'h0);
    chk("rst_perr", 16'(parity_err), 16'h0);
    reset = 1'b0;
    tick();

    // ack with nothing pending is ignored
    ack_once();
    chk("idle_ack", 16'(out_valid), 16'h0);

    // 0xA5 back-to-back strobes
    strobe(1'b0, 0, 1'b0);
    chk("a5_busy_mid", 16'(busy), 16'h1);
    for (int i = 0; i < 8; i++) strobe(((8'hA5 >> i) & 8'h1) != 0, 0, 1'b0);
`ifdef SERIAL_RX_PARITY_EN
    strobe(1'b0, 0, 1'b0);
`endif
    chk("a5_valid_pre", 16'(out_valid), 16'h0);
    strobe(1'b1, 0, 1'b0);
    chk("a5_valid", 16'(out_valid), 16'h1);
    chk("a5_data", 16'(data_out), 16'h00A5);
    chk("a5_busy", 16'(busy), 16'h0);
    tick();
    chk("a5_hold", 16'(out_valid), 16'h1);
    ack_once();
    chk("a5_ack", 16'(out_valid), 16'h0);

    // same frame, strobe every 3rd cycle, line toggling off-strobe
    send_frame(8'hA5, 1'b1, 2, 1'b0);
    chk("gap_valid", 16'(out_valid), 16'h1);
    chk("gap_data", 16'(data_out), 16'h00A5);
    ack_once();

    // 0x3C with bad stop bit
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    chk("fe_pulse", 16'(frame_err), 16'h1);
    chk("fe_valid", 16'(out_valid), 16'h0);
    chk("fe_data", 16'(data_out), 16'h00A5);
    tick();
    chk("fe_end", 16'(frame_err), 16'h0);

    // overrun: second word dropped without ack
    send_frame(8'h11, 1'b1, 0, 1'b0);
    chk("ov_data1", 16'(data_out), 16'h0011);
    send_frame(8'h22, 1'b1, 0, 1'b0);
    chk("ov_pulse", 16'(overrun), 16'h1);
    chk("ov_data", 16'(data_out), 16'h0011);
    chk("ov_valid", 16'(out_valid), 16'h1);
    tick();
    chk("ov_end", 16'(overrun), 16'h0);

    // ack on the landing edge: new word replaces, valid stays
    send_frame(8'h22, 1'b1, 0, 1'b1);
    chk("ak_data", 16'(data_out), 16'h0022);
    chk("ak_valid", 16'(out_valid), 16'h1);
    chk("ak_ovr", 16'(overrun), 16'h0);
    ack_once();

    // reset after four data bits
    strobe(1'b0, 0, 1'b0);
    strobe(1'b1, 0, 1'b0);
    strobe(1'b1, 0, 1'b0);
    strobe(1'b0, 0, 1'b0);
    strobe(1'b1, 0, 1'b0);
    reset = 1'b1;
    tick();
    chk("mr_data", 16'(data_out), 16'h0000);
    chk("mr_valid", 16'(out_valid), 16'h0);
    chk("mr_busy", 16'(busy), 16'h0);
    chk("mr_err", 16'({frame_err, overrun, parity_err}), 16'h0);
    reset = 1'b0;
    tick();
    send_frame(8'h0F, 1'b1, 0, 1'b0);
    chk("mr_data2", 16'(data_out), 16'h000F);
    chk("mr_valid2", 16'(out_valid), 16'h1);
    ack_once();

`ifdef SERIAL_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 0, 1'b0);
    chk("par_ok_v", 16'(out_valid), 16'h1);
    chk("par_ok_d", 16'(data_out), 16'h0007);
    chk("par_ok_e", 16'(parity_err), 16'h0);
    ack_once();
    strobe(1'b0, 0, 1'b0);
    for (int i = 0; i < 8; i++) strobe(((8'h07 >> i) & 8'h1) != 0, 0, 1'b0);
    strobe(1'b0, 0, 1'b0);
    strobe(1'b1, 0, 1'b0);
    chk("par_bad_e", 16'(parity_err), 16'h1);
    chk("par_bad_v", 16'(out_valid), 16'h0);
    chk("par_bad_d", 16'(data_out), 16'h0007);
    tick();
    chk("par_bad_end", 16'(parity_err), 16'h0);
`else
    chk("par_tied", 16'(parity_err), 16'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_byte_receiver.md
Name: serial_byte_receiver

Overview:
- Serial-in/parallel-out receiver; the receive end of the team's 8-bit right-shifting parallel-load shifter link.
- Takes one bit per bit-strobe, LSB first, framed by a start bit (0) and a stop bit (1).
- Reassembles the word by right-shifting and presents it on a valid/ack parallel interface.
- Sits between a serial line (switch- or shifter-driven) and LED/register consumers.

Parameters:
- DATA_W, 8, data bits per frame (2..16).
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W >= DATA_W.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_en  input  1  bit strobe; ser_in is sampled only on edges where bit_en=1.
- ser_in  input  1  serial line, idles high.
- out_ack  input  1  consumer accepts data_out while out_valid=1.
- data_out  output  DATA_W  last accepted word.
- out_valid  output  1  data_out holds an unconsumed word.
- busy  output  1  high when state != IDLE.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: frame completed while out_valid=1 and no ack.
- parity_err  output  1  one-cycle pulse (see Optional Feature); constant 0 when the feature is compiled out.

Behaviour:
- Reset (reset=1 at a clk edge) takes priority over everything, including mid-frame.
  - Next state: state=IDLE, shift reg=0, bit count=0, data_out=0.
  - out_valid, busy, frame_err, overrun and parity_err all =0.
  - Any partial frame is discarded.
- States: IDLE, DATA, PARITY (only with the feature), STOP. Transitions happen only on edges with bit_en=1; with bit_en=0, state, shift reg and count hold.
- IDLE: if ser_in=0, go to DATA with count=0. If ser_in=1, stay in IDLE.
- DATA: shift reg <= {ser_in, shift[DATA_W-1:1]}; count++.
  - When the sampled bit is the last one (count==DATA_W-1), go to PARITY or STOP.
  - After DATA_W strobes, the first received bit sits at bit 0.
- STOP with ser_in=1 (frame completes):
  - If out_valid=0, or out_ack=1 on the same edge: data_out <= shift reg, out_valid <= 1.
  - Otherwise: data_out is kept, the new word is dropped, and overrun pulses for 1 cycle.
  - In all cases, go to IDLE.
- STOP with ser_in=0: frame_err pulses for 1 cycle, the word is discarded, go to IDLE. The next strobe with ser_in=0 starts a new frame; a held-low line produces back-to-back frame errors, which is accepted.
- Handshake:
  - out_valid, once set, stays high until an edge with out_ack=1. It then clears on that edge unless a new frame lands on the same edge, in which case it stays 1 with the new data.
  - out_ack while out_valid=0 is ignored.
  - data_out is stable while out_valid=1.
- Latency: out_valid rises on the same edge that samples a good stop bit, i.e. visible the cycle after that strobe.
- Error pulses are registered, last exactly one clk cycle, and do not depend on bit_en after that edge.
- busy is a registered decode of state.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows the data; the frame is start + DATA_W + parity + stop.
  - The PARITY state samples it and checks XOR(data bits, parity bit)==0.
  - On mismatch, a pulse is issued on the edge that samples a good stop bit: parity_err=1 for 1 cycle, word discarded, out_valid unchanged.
  - A stop error takes precedence: frame_err only.
- Undefined: no PARITY state, frame is start + DATA_W + stop, parity_err tied 0.

Decomposition:
- Shared package serial_pkg holds:
  - state enum rx_state_t (IDLE, DATA, PARITY, STOP);
  - constants SER_IDLE_LVL=1, SER_START_LVL=0, SER_STOP_LVL=1;
  - the default width 8.
- Sub-module rx_shift_reg: DATA_W-bit right-shift register with shift enable and synchronous clear.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- 0xA5 frame: ser_in 0,1,0,1,0,0,1,0,1,1 on ten strobes -> out_valid=1, data_out=0xA5, busy=0 after the stop strobe; ack -> out_valid=0 next cycle.
- Gapped strobes: same 0xA5 frame with bit_en high only every 3rd cycle and ser_in toggling on the idle cycles -> identical result; off-strobe values are ignored.
- Framing error: 0x3C frame with stop bit=0 -> frame_err 1-cycle pulse, out_valid stays 0, data_out unchanged.
- Overrun: receive 0x11, then 0x22 without ack -> overrun pulse, data_out=0x11. Repeat with ack asserted on the 0x22 stop edge -> data_out=0x22, out_valid stays 1, no overrun.
- Reset mid-frame: reset after 4 data bits, then a full 0x0F frame -> data_out=0x0F; no stale bits; all outputs 0 during reset.
- With SERIAL_RX_PARITY_EN: 0x07 with parity 1 -> valid; 0x07 with parity 0 -> parity_err pulse, out_valid stays 0.
